alu_rsp_deserializer: RTL and testbench
=======================================

# alu_rsp_deserializer

Synthesizable receive stage that sits between the serial output of the ALU DUT and the scoreboard. It samples the DUT's bit-serial response line and reassembles framed words into one parallel response record (16-bit result plus 8-bit status). It also flags malformed or stalled responses. The scoreboard consumes the record on a single-cycle `rsp_valid` strobe instead of probing BFM signals directly.

## Interface
- `TIMEOUT_CYCLES`, default 1000: maximum idle cycles between words inside one response before the response is aborted.
- `clk  in  1`: single clock; all sampling on rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `sout  in  1`: DUT serial response line; idles high.
- `rsp_valid  out  1`: one-cycle strobe; `data_result`/`status` hold a complete response.
- `data_result  out  16`: reassembled result; MSB word first.
- `status  out  8`: status byte from the control word.
- `frame_err  out  1`: one-cycle strobe on any framing, sequence or timeout error.

## Operation
- Word format, 11 bits, one bit per clock: start `0`, ctl bit, d7..d0 (MSB first), stop `1`.
- ctl=0 marks a data word; ctl=1 marks the status (terminating) word.
- Legal responses:
  - two data words (result[15:8], then result[7:0]) followed by one status word;
  - a lone status word whose status ≠ `S_NO_ERROR`. In this case `data_result` is published as 16'h0000.
- FSM states: `IDLE` (sout=1, waiting for start), `RX` (shifting 10 bits after start), `EVAL` (one cycle; checks stop/ctl/sequence), `GAP` (between words of one response; runs the timeout counter).
- `IDLE`/`GAP` → `RX`: sout sampled 0.
- `RX` → `EVAL`: after the stop bit is sampled (bit counter 0..9 wraps).
- `EVAL` → `GAP`: stored data word, data count < 2.
- `EVAL` → `IDLE`: on publish or on error.
- Errors, each giving a `frame_err` pulse, discarding the partial response and returning to `IDLE`:
  - stop bit = 0;
  - third data word;
  - status word after exactly one data word;
  - lone status word carrying `S_NO_ERROR`;
  - `GAP` counter reaching `TIMEOUT_CYCLES`.
- `rsp_valid` and `frame_err` are never asserted in the same cycle.
- `data_result`/`status` hold their last published values until the next publish.
- Status is passed through unchecked apart from the lone-word rule; judging correctness is the scoreboard's job.

## Timing
- Reset values: all outputs 0, FSM `IDLE`, word/data/timeout counters 0.
- Reset is effective immediately (asynchronous). Reset mid-word or mid-response aborts with no strobe.
- Latency: `rsp_valid` is asserted on the second rising edge after the edge that samples the status word's stop bit (the `EVAL` cycle is registered). The same latency applies to `frame_err` for stop/sequence errors.
- Back-to-back: a start bit sampled in the `EVAL` cycle is not lost. The `EVAL` cycle also checks `sout` and enters `RX` directly, so zero-gap words and zero-gap responses are accepted.
- Timeout counter:
  - clears on entering `GAP` and counts each `GAP` cycle;
  - `frame_err` is asserted in the cycle the count reaches `TIMEOUT_CYCLES`;
  - the counter is not active in `IDLE`.
- Counter widths: bit counter 4 bits; data-word counter 2 bits; timeout counter `$clog2(TIMEOUT_CYCLES+1)` bits.

## Structure
- `S_NO_ERROR` and `S_INVALID_COMMAND` are taken from `alu_pkg`.
- Add to `alu_pkg`:
  - the FSM typedef `rsp_state_t` (`IDLE`, `RX`, `GAP`, `EVAL`);
  - constant `RSP_WORD_BITS` = 11.
- One sub-module, `alu_serial_word_rx`:
  - contains the start detect, the 10-bit shift register and the stop check;
  - outputs `word_valid`, `word_ctl`, `word_data[7:0]` and `word_stop_err`.
- The top level owns the word-sequence FSM, the timeout and the output registers.

## Test plan
- Reset then `sout`=1 for 50 cycles → all outputs 0, no strobes.
- Words 0x12 (ctl 0), 0x34 (ctl 0), `S_NO_ERROR` (ctl 1), no gaps → single `rsp_valid` 2 edges after the last stop sample; `data_result`=16'h1234; `status`=`S_NO_ERROR`.
- Lone word `S_INVALID_COMMAND` (ctl 1) → `rsp_valid`; `data_result`=16'h0000; `status`=`S_INVALID_COMMAND`.
- Second data word sent with stop bit 0 → one `frame_err`, no `rsp_valid`. Then 0xAB, 0xCD, `S_NO_ERROR` → `data_result`=16'hABCD.
- `TIMEOUT_CYCLES`=16: two data words, then `sout`=1 → `frame_err` exactly 16 `GAP` cycles after the second word's `EVAL`. A following legal response decodes correctly.
- `rst` pulsed during the status word's data bits → outputs 0 asynchronously, no strobe. Then two zero-gap responses 0x0102 and 0xFFFE → two `rsp_valid` pulses with those values.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: status codes and the serial response framing.
package alu_pkg;

  localparam logic [7:0] S_NO_ERROR        = 8'h00;
  localparam logic [7:0] S_INVALID_COMMAND = 8'h01;

  // start + ctl + 8 data bits + stop
  localparam int unsigned RSP_WORD_BITS = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    GAP  = 2'd2,
    EVAL = 2'd3
  } rsp_state_t;

endpackage

// File: rtl/alu_serial_word_rx.sv
// Bit-serial word receiver: detects the start bit, shifts in ctl/data/stop,
// and presents the assembled word for one cycle after the stop bit.
module alu_serial_word_rx
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sout,
  input  logic       i_arm,
  output logic       word_last,
  output logic       word_valid,
  output logic       word_ctl,
  output logic [7:0] word_data,
  output logic       word_stop_err
);

  // bits following the start bit: ctl, d7..d0, stop
  localparam int unsigned SHIFT_W  = RSP_WORD_BITS - 1;
  localparam logic [3:0]  LAST_IDX = 4'(SHIFT_W - 1);

  logic               r_busy;
  logic [3:0]         r_bit_cnt;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_valid;

  // high in the cycle whose closing edge samples the stop bit
  assign word_last = r_busy && (r_bit_cnt == LAST_IDX);

  // start detect, shift register and bit counter (0..9, wraps on stop)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= word_last;
      if (!r_busy) begin
        if (i_arm && !sout) begin
          r_busy    <= 1'b1;
          r_bit_cnt <= '0;
        end
      end else begin
        r_shift <= {r_shift[SHIFT_W-2:0], sout};
        if (word_last) begin
          r_busy    <= 1'b0;
          r_bit_cnt <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end
    end
  end

  assign word_valid    = r_valid;
  assign word_ctl      = r_shift[SHIFT_W-1];
  assign word_data     = r_shift[SHIFT_W-2:1];
  assign word_stop_err = ~r_shift[0];

endmodule

// File: rtl/alu_rsp_deserializer.sv
// Reassembles framed serial ALU responses into a result/status record,
// flagging stop, sequence and inter-word timeout errors.
module alu_rsp_deserializer
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sout,
  output logic        rsp_valid,
  output logic [15:0] data_result,
  output logic [7:0]  status,
  output logic        frame_err
);

  localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  rsp_state_t  r_state, w_state_nxt;
  logic [1:0]  r_dcnt, w_dcnt_nxt;
  logic [TW-1:0] r_tcnt, w_tcnt_nxt;
  logic [7:0]  r_hi, r_lo;
  logic        w_store_hi, w_store_lo;
  logic        w_pub, w_err, w_timeout, w_arm;
  logic [15:0] w_res;

  // EVAL decision registered once more before it reaches the outputs
  logic        r_pub_q, r_err_q;
  logic [15:0] r_res_q;
  logic [7:0]  r_sts_q;

  logic       w_word_last, w_word_valid, w_word_ctl, w_word_stop_err;
  logic [7:0] w_word_data;

  alu_serial_word_rx u_rx (
    .clk          (clk),
    .rst          (rst),
    .sout         (sout),
    .i_arm        (w_arm),
    .word_last    (w_word_last),
    .word_valid   (w_word_valid),
    .word_ctl     (w_word_ctl),
    .word_data    (w_word_data),
    .word_stop_err(w_word_stop_err)
  );

  // state, data-word count and gap timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_dcnt  <= '0;
      r_tcnt  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
      if (w_store_hi) r_hi <= w_word_data;
      if (w_store_lo) r_lo <= w_word_data;
    end
  end

  // word-sequence rules; a start bit is honoured in IDLE, GAP and EVAL
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_tcnt_nxt  = r_tcnt;
    w_store_hi  = 1'b0;
    w_store_lo  = 1'b0;
    w_pub       = 1'b0;
    w_err       = 1'b0;
    w_timeout   = 1'b0;
    w_arm       = 1'b0;
    w_res       = 16'h0000;
    case (r_state)
      IDLE: begin
        w_arm      = 1'b1;
        w_tcnt_nxt = '0;
        if (!sout) w_state_nxt = RX;
      end
      RX: begin
        if (w_word_last) w_state_nxt = EVAL;
      end
      GAP: begin
        w_arm = 1'b1;
        if (!sout) begin
          w_state_nxt = RX;
        end else if (r_tcnt == TMO_LAST) begin
          w_timeout   = 1'b1;
          w_dcnt_nxt  = '0;
          w_tcnt_nxt  = '0;
          w_state_nxt = IDLE;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
      EVAL: begin
        w_arm      = 1'b1;
        w_tcnt_nxt = '0;
        if (w_word_stop_err || !w_word_valid) begin
          w_err = 1'b1;
        end else if (!w_word_ctl) begin
          if (r_dcnt == 2'd2) begin
            w_err = 1'b1;
          end else begin
            w_store_hi = (r_dcnt == 2'd0);
            w_store_lo = (r_dcnt == 2'd1);
            w_dcnt_nxt = r_dcnt + 2'd1;
          end
        end else if (r_dcnt == 2'd2) begin
          w_pub = 1'b1;
          w_res = {r_hi, r_lo};
        end else if (r_dcnt == 2'd0 && w_word_data != S_NO_ERROR) begin
          w_pub = 1'b1;
        end else begin
          w_err = 1'b1;
        end
        if (w_pub || w_err) w_dcnt_nxt = '0;
        if (!sout)                w_state_nxt = RX;
        else if (w_pub || w_err)  w_state_nxt = IDLE;
        else                      w_state_nxt = GAP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // output stage: publish strobe and record, error strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pub_q     <= 1'b0;
      r_err_q     <= 1'b0;
      r_res_q     <= '0;
      r_sts_q     <= '0;
      rsp_valid   <= 1'b0;
      frame_err   <= 1'b0;
      data_result <= '0;
      status      <= '0;
    end else begin
      r_pub_q <= w_pub;
      r_err_q <= w_err;
      if (w_pub) begin
        r_res_q <= w_res;
        r_sts_q <= w_word_data;
      end
      rsp_valid <= r_pub_q;
      frame_err <= r_err_q | w_timeout;
      if (r_pub_q) begin
        data_result <= r_res_q;
        status      <= r_sts_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_rsp_deserializer.sv
// Directed bench with a scoreboard queue; the monitor checks every strobe.
module tb_alu_rsp_deserializer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sout;
  logic        rsp_valid;
  logic [15:0] data_result;
  logic [7:0]  status;
  logic        frame_err;

  alu_rsp_deserializer #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .sout       (sout),
    .rsp_valid  (rsp_valid),
    .data_result(data_result),
    .status     (status),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [15:0] res;
    logic [7:0]  sts;
    int          at;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic exp_rsp(input logic [15:0] res, input logic [7:0] sts, input int at);
    exp_t e;
    e.is_err = 1'b0; e.res = res; e.sts = sts; e.at = at;
    q.push_back(e);
  endtask

  task automatic exp_err(input int at);
    exp_t e;
    e.is_err = 1'b1; e.res = '0; e.sts = '0; e.at = at;
    q.push_back(e);
  endtask

  // one 11-bit word, one bit per clock; line returns high afterwards
  task automatic send(input logic ctl, input logic [7:0] d, input logic stop);
    logic [10:0] w;
    w = {1'b0, ctl, d, stop};
    for (int i = 10; i >= 0; i--) begin
      sout = w[i];
      @(posedge clk); #1;
    end
    sout = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (rsp_valid || frame_err)) begin
      chk("strobe_excl", 32'(rsp_valid & frame_err), 32'd0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual rsp_valid=%b frame_err=%b required none", rsp_valid, frame_err);
      end else begin
        e = q.pop_front();
        chk("strobe_kind", 32'(frame_err), 32'(e.is_err));
        chk("strobe_cycle", 32'(cyc), 32'(e.at));
        if (!e.is_err) begin
          chk("data_result", 32'(data_result), 32'(e.res));
          chk("status", 32'(status), 32'(e.sts));
        end
      end
    end
  end

  initial begin
    rst  = 1'b1;
    sout = 1'b1;
    idle(3);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_data", 32'(data_result), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    rst = 1'b0;
    idle(50);
    chk("idle_data", 32'(data_result), 32'd0);
    chk("idle_status", 32'(status), 32'd0);

    // basic response, zero gap
    send(1'b0, 8'h12, 1'b1);
    send(1'b0, 8'h34, 1'b1);
    send(1'b1, S_NO_ERROR, 1'b1);
    exp_rsp(16'h1234, S_NO_ERROR, cyc + 2);
    idle(5);

    // lone error status word
    send(1'b1, S_INVALID_COMMAND, 1'b1);
    exp_rsp(16'h0000, S_INVALID_COMMAND, cyc + 2);
    idle(5);

    // stop bit error on the second data word, then a clean response
    send(1'b0, 8'h11, 1'b1);
    send(1'b0, 8'h22, 1'b0);
    exp_err(cyc + 2);
    idle(5);
    chk("hold_data", 32'(data_result), 32'h0000);
    chk("hold_status", 32'(status), 32'(S_INVALID_COMMAND));
    send(1'b0, 8'hAB, 1'b1);
    send(1'b0, 8'hCD, 1'b1);
    send(1'b1, S_NO_ERROR, 1'b1);
    exp_rsp(16'hABCD, S_NO_ERROR, cyc + 2);
    idle(5);

    // sequence errors
    send(1'b0, 8'h01, 1'b1);
    send(1'b0, 8'h02, 1'b1);
    send(1'b0, 8'h03, 1'b1);
    exp_err(cyc + 2);
    idle(5);
    send(1'b0, 8'h05, 1'b1);
    send(1'b1, S_NO_ERROR, 1'b1);
    exp_err(cyc + 2);
    idle(5);
    send(1'b1, S_NO_ERROR, 1'b1);
    exp_err(cyc + 2);
    idle(5);
    chk("hold_after_err", 32'(data_result), 32'hABCD);

    // longest legal gaps (15 GAP cycles) between words
    send(1'b0, 8'h77, 1'b1);
    idle(16);
    send(1'b0, 8'h88, 1'b1);
    idle(16);
    send(1'b1, S_INVALID_COMMAND, 1'b1);
    exp_rsp(16'h7788, S_INVALID_COMMAND, cyc + 2);
    idle(5);

    // timeout: 16 GAP cycles after the second word's EVAL
    send(1'b0, 8'h55, 1'b1);
    send(1'b0, 8'h66, 1'b1);
    exp_err(cyc + 17);
    idle(25);
    send(1'b0, 8'h9A, 1'b1);
    send(1'b0, 8'hBC, 1'b1);
    send(1'b1, S_NO_ERROR, 1'b1);
    exp_rsp(16'h9ABC, S_NO_ERROR, cyc + 2);
    idle(5);

    // asynchronous reset in the middle of the status word
    send(1'b0, 8'h21, 1'b1);
    send(1'b0, 8'h43, 1'b1);
    sout = 1'b0; idle(1);
    sout = 1'b1; idle(1);
    sout = 1'b0; idle(1);
    sout = 1'b1; #2;
    rst = 1'b1; #1;
    chk("async_rst_data", 32'(data_result), 32'd0);
    chk("async_rst_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5);

    // two zero-gap responses
    send(1'b0, 8'h01, 1'b1);
    send(1'b0, 8'h02, 1'b1);
    send(1'b1, S_NO_ERROR, 1'b1);
    exp_rsp(16'h0102, S_NO_ERROR, cyc + 2);
    send(1'b0, 8'hFF, 1'b1);
    send(1'b0, 8'hFE, 1'b1);
    send(1'b1, S_NO_ERROR, 1'b1);
    exp_rsp(16'hFFFE, S_NO_ERROR, cyc + 2);
    idle(10);

    chk("pending_expected", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
